// File: rtl/lsu_pkg.sv
// Shared state encoding, funct3 codes and access-size helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte-lane mask of an access before it is shifted to its byte offset.
    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        logic [3:0] mask;
        case (funct3)
            F3_B, F3_BU: mask = 4'b0001;
            F3_H, F3_HU: mask = 4'b0011;
            F3_W:        mask = 4'b1111;
            default:     mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Stores only have signed-looking encodings; the unsigned ones are load-only.
    function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
        logic ok;
        case (funct3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed bytes from the two-word merge register and extends them.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] i_merge,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_rdata
);

    logic [31:0] w_low;

    // Drop the leading offset bytes, then sign- or zero-extend to 32 bits.
    always_comb begin
        w_low = i_merge[{i_off, 3'b000} +: 32];
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_low[7]}}, w_low[7:0]};
            F3_BU:   o_rdata = {24'h000000, w_low[7:0]};
            F3_H:    o_rdata = {{16{w_low[15]}}, w_low[15:0]};
            F3_HU:   o_rdata = {16'h0000, w_low[15:0]};
            F3_W:    o_rdata = w_low;
            default: o_rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store initiator: splits unaligned accesses into up to two word
// transactions, merges read bytes, and returns one response per request.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    // Highest legal word address, one bit wider than the address so that a
    // split access wrapping past 2^ADDR_WIDTH compares as out of range.
    localparam logic [ADDR_WIDTH:0] LAST_WORD = (ADDR_WIDTH + 1)'(MEM_SIZE * 4 - 4);

    // Reset synchroniser: assertion is immediate, release is aligned to clk.
    logic r_rst_meta;
    logic r_rst_sync;

    lsu_state_t r_state;
    lsu_state_t w_state_next;

    logic                  r_store;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_err;
    logic [63:0]           r_merge;

    logic                  w_accept;
    logic [7:0]            w_req_lane;
    logic                  w_req_split;
    logic [ADDR_WIDTH-1:0] w_req_base;
    logic [ADDR_WIDTH:0]   w_req_last;
    logic                  w_req_oob;
    logic                  w_req_err;

    logic [7:0]              w_lane;
    logic [ADDR_WIDTH-1:0]   w_base;
    logic [2*DATA_WIDTH-1:0] w_wshift;
    logic [DATA_WIDTH-1:0]   w_rd_lanes;
    logic [31:0]             w_align_rdata;

    // Two-stage synchroniser generating the internal reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    assign w_accept = req_valid && (r_state == IDLE);

    // Decode of the incoming request: lane span, last word touched, and legality.
    always_comb begin
        w_req_lane  = {4'b0000, size_mask(req_funct3)} << req_addr[1:0];
        w_req_split = |w_req_lane[7:4];
        w_req_base  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
        w_req_last  = {1'b0, w_req_base} + {{(ADDR_WIDTH-2){1'b0}}, w_req_split, 2'b00};
        w_req_oob   = w_req_last > LAST_WORD;
        w_req_err   = !funct3_legal(req_store, req_funct3) || w_req_oob;
    end

    // Lane mask and store data of the latched request, shifted over two words.
    always_comb begin
        w_lane   = {4'b0000, size_mask(r_funct3)} << r_addr[1:0];
        w_base   = {r_addr[ADDR_WIDTH-1:2], 2'b00};
        w_wshift = {{DATA_WIDTH{1'b0}}, r_wdata} << {r_addr[1:0], 3'b000};
    end

    // Keep only the read bytes belonging to the access; others merge in as zero.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_rd_lanes[8*gi +: 8] = mem_be[gi] ? mem_rdata[8*gi +: 8] : 8'h00;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: errors skip the memory phases entirely.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = w_req_err ? RESP : ACC0;
                end
            end
            ACC0:    w_state_next = (|w_lane[7:4]) ? ACC1 : RESP;
            ACC1:    w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Request latch and load-data merge register.
    always_ff @(posedge clk or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_store  <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
            r_merge  <= '0;
        end else if (w_accept) begin
            r_store  <= req_store;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_err    <= w_req_err;
            r_merge  <= '0;
        end else if ((r_state == ACC0) && !r_store) begin
            r_merge[31:0] <= w_rd_lanes;
        end else if ((r_state == ACC1) && !r_store) begin
            r_merge[63:32] <= w_rd_lanes;
        end
    end

    lsu_load_align u_align (
        .i_merge  (r_merge),
        .i_off    (r_addr[1:0]),
        .i_funct3 (r_funct3),
        .o_rdata  (w_align_rdata)
    );

    // Output decode from state; strobes are state-qualified so a reset drops them at once.
    always_comb begin
        req_ready  = 1'b0;
        mem_addr   = w_base;
        mem_wdata  = w_wshift[DATA_WIDTH-1:0];
        mem_we     = 1'b0;
        mem_be     = 4'b0000;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        case (r_state)
            IDLE: req_ready = 1'b1;
            ACC0: begin
                mem_be = w_lane[3:0];
                mem_we = r_store;
            end
            ACC1: begin
                mem_addr  = w_base + ADDR_WIDTH'(4);
                mem_wdata = w_wshift[2*DATA_WIDTH-1:DATA_WIDTH];
                mem_be    = w_lane[7:4];
                mem_we    = r_store;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                if (!r_err && !r_store) begin
                    resp_rdata = w_align_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-enabled word memory model.
module tb_load_store_unit;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(1024)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: async read, byte-enabled sync write, preloaded before use.
    logic [31:0] tb_mem [0:1023];
    logic        mem_init_done;

    assign mem_rdata = (mem_addr < 32'h0000_1000) ? tb_mem[mem_addr[11:2]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 1024; i++) tb_mem[i] <= 32'h0;
            tb_mem[4]    <= 32'h1122_3344;
            tb_mem[16]   <= 32'h0102_0304;
            tb_mem[17]   <= 32'h5566_7788;
            tb_mem[1023] <= 32'hCAFE_F00D;
        end else if (mem_we && (mem_addr < 32'h0000_1000)) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) tb_mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Results of the latest transaction.
    logic [31:0] got_rdata;
    logic        got_err;
    int          got_lat;
    int          ncyc;
    int          we_cnt;
    logic [3:0]  first_be;
    logic [31:0] cyc_addr  [8];
    logic [3:0]  cyc_be    [8];
    logic        cyc_we    [8];
    logic [31:0] cyc_wdata [8];

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 16) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
        int s;
        wait_idle();
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        first_be  = mem_be;
        ncyc      = 0;
        we_cnt    = 0;
        got_rdata = 32'h0;
        got_err   = 1'b0;
        s = 0;
        while (!resp_valid && s < 8) begin
            cyc_addr[s]  = mem_addr;
            cyc_be[s]    = mem_be;
            cyc_we[s]    = mem_we;
            cyc_wdata[s] = mem_wdata;
            if (mem_be != 4'b0000) ncyc++;
            if (mem_we) we_cnt++;
            s++;
            @(posedge clk);
            #1;
        end
        if (resp_valid) begin
            got_lat   = s + 1;
            got_rdata = resp_rdata;
            got_err   = resp_err;
            if (mem_be != 4'b0000) ncyc++;
            if (mem_we) we_cnt++;
        end else begin
            got_lat = 99;
        end
        $display("[TB] req st=%0b f3=%0d addr=%h wd=%h -> rdata=%h err=%0b lat=%0d",
                 st, f3, a, wd, got_rdata, got_err, got_lat);
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [3:0]  exp_be0;
        int          exp_ncyc;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    initial begin
        vec_t v;
        int acc, rsp, bad, we_seen;

        vecs[0]  = '{1'b0, 3'd2, 32'h0000_0010, 32'h0, 32'h1122_3344, 1'b0, 2, 4'b1111, 1};
        vecs[1]  = '{1'b1, 3'd0, 32'h0000_0013, 32'h0000_0080, 32'h0, 1'b0, 2, 4'b1000, 1};
        vecs[2]  = '{1'b0, 3'd0, 32'h0000_0013, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 4'b1000, 1};
        vecs[3]  = '{1'b0, 3'd4, 32'h0000_0013, 32'h0, 32'h0000_0080, 1'b0, 2, 4'b1000, 1};
        vecs[4]  = '{1'b0, 3'd2, 32'h0000_0010, 32'h0, 32'h8022_3344, 1'b0, 2, 4'b1111, 1};
        vecs[5]  = '{1'b0, 3'd1, 32'h0000_0012, 32'h0, 32'hFFFF_8022, 1'b0, 2, 4'b1100, 1};
        vecs[6]  = '{1'b0, 3'd5, 32'h0000_0012, 32'h0, 32'h0000_8022, 1'b0, 2, 4'b1100, 1};
        vecs[7]  = '{1'b0, 3'd1, 32'h0000_0011, 32'h0, 32'h0000_2233, 1'b0, 2, 4'b0110, 1};
        vecs[8]  = '{1'b0, 3'd2, 32'h0000_0022, 32'h0, 32'hAABB_CCDD, 1'b0, 3, 4'b1100, 2};
        vecs[9]  = '{1'b0, 3'd5, 32'h0000_0023, 32'h0, 32'h0000_BBCC, 1'b0, 3, 4'b1000, 2};
        vecs[10] = '{1'b0, 3'd0, 32'h0000_0025, 32'h0, 32'hFFFF_FFAA, 1'b0, 2, 4'b0010, 1};
        vecs[11] = '{1'b0, 3'd1, 32'h0000_0FFF, 32'h0, 32'h0, 1'b1, 1, 4'b0000, 0};
        vecs[12] = '{1'b0, 3'd3, 32'h0000_0010, 32'h0, 32'h0, 1'b1, 1, 4'b0000, 0};
        vecs[13] = '{1'b1, 3'd4, 32'h0000_0010, 32'h1234_5678, 32'h0, 1'b1, 1, 4'b0000, 0};
        vecs[14] = '{1'b0, 3'd2, 32'h0000_1000, 32'h0, 32'h0, 1'b1, 1, 4'b0000, 0};
        vecs[15] = '{1'b0, 3'd2, 32'h0000_0FFC, 32'h0, 32'hCAFE_F00D, 1'b0, 2, 4'b1111, 1};
        vecs[16] = '{1'b0, 3'd2, 32'hFFFF_FFFE, 32'h0, 32'h0, 1'b1, 1, 4'b0000, 0};
        vecs[17] = '{1'b0, 3'd4, 32'h0000_0FFF, 32'h0, 32'h0000_00CA, 1'b0, 2, 4'b1000, 1};
        vecs[18] = '{1'b0, 3'd1, 32'h0000_0FFE, 32'h0, 32'hFFFF_CAFE, 1'b0, 2, 4'b1100, 1};
        vecs[19] = '{1'b1, 3'd2, 32'h0000_0FFD, 32'h9999_9999, 32'h0, 1'b1, 1, 4'b0000, 0};
        vecs[20] = '{1'b0, 3'd2, 32'h0000_0FFC, 32'h0, 32'hCAFE_F00D, 1'b0, 2, 4'b1111, 1};
        vecs[21] = '{1'b1, 3'd1, 32'h0000_0013, 32'h0000_BEEF, 32'h0, 1'b0, 3, 4'b1000, 2};
        vecs[22] = '{1'b0, 3'd2, 32'h0000_0011, 32'h0, 32'hBEEF_2233, 1'b0, 3, 4'b1110, 2};
        vecs[23] = '{1'b0, 3'd0, 32'h0000_0014, 32'h0, 32'hFFFF_FFBE, 1'b0, 2, 4'b0001, 1};

        reset_n       = 1'b0;
        req_valid     = 1'b0;
        req_store     = 1'b0;
        req_funct3    = 3'b000;
        req_addr      = 32'h0;
        req_wdata     = 32'h0;
        mem_init_done = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_init_done = 1'b1;
        check("rst_req_ready",  {31'h0, req_ready},  32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_err",   {31'h0, resp_err},   32'h0);
        check("rst_resp_rdata", resp_rdata,          32'h0);
        check("rst_mem_we",     {31'h0, mem_we},     32'h0);
        check("rst_mem_be",     {28'h0, mem_be},     32'h0);
        check("rst_mem_addr",   mem_addr,            32'h0);
        check("rst_mem_wdata",  mem_wdata,           32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);

        // Split store: SW 0xAABBCCDD at 0x22.
        run_req(1'b1, 3'd2, 32'h0000_0022, 32'hAABB_CCDD);
        check("sw_split_lat",     32'(got_lat),               32'd3);
        check("sw_split_err",     {31'h0, got_err},           32'h0);
        check("sw_split_rdata",   got_rdata,                  32'h0);
        check("sw_acc0_addr",     cyc_addr[0],                32'h0000_0020);
        check("sw_acc0_be",       {28'h0, cyc_be[0]},         32'h0000_000C);
        check("sw_acc0_we",       {31'h0, cyc_we[0]},         32'h1);
        check("sw_acc0_wdata_hi", {16'h0, cyc_wdata[0][31:16]}, 32'h0000_CCDD);
        check("sw_acc1_addr",     cyc_addr[1],                32'h0000_0024);
        check("sw_acc1_be",       {28'h0, cyc_be[1]},         32'h0000_0003);
        check("sw_acc1_we",       {31'h0, cyc_we[1]},         32'h1);
        check("sw_acc1_wdata_lo", {16'h0, cyc_wdata[1][15:0]},  32'h0000_AABB);

        // Table of directed vectors; memory contents carry over between entries.
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            run_req(v.st, v.f3, v.addr, v.wd);
            check($sformatf("v%0d_rdata", i), got_rdata,           v.exp_rdata);
            check($sformatf("v%0d_err", i),   {31'h0, got_err},    {31'h0, v.exp_err});
            check($sformatf("v%0d_lat", i),   32'(got_lat),        32'(v.exp_lat));
            check($sformatf("v%0d_be0", i),   {28'h0, first_be},   {28'h0, v.exp_be0});
            check($sformatf("v%0d_ncyc", i),  32'(ncyc),           32'(v.exp_ncyc));
            check($sformatf("v%0d_we", i),    32'(we_cnt),         v.st ? 32'(v.exp_ncyc) : 32'd0);
        end

        // Back-to-back illegal loads with req_valid held: accept only from IDLE.
        wait_idle();
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b011;
        req_addr   = 32'h0000_0010;
        acc = 0; rsp = 0; bad = 0; we_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (req_ready) acc++;
            if (resp_valid) begin
                rsp++;
                if (!resp_err || resp_rdata != 32'h0) bad++;
            end
            if (mem_we || mem_be != 4'b0000) we_seen++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        $display("[TB] b2b illegal: accepts=%0d responses=%0d", acc, rsp);
        check("b2b_err_accepts", 32'(acc),     32'd4);
        check("b2b_err_resps",   32'(rsp),     32'd4);
        check("b2b_err_flags",   32'(bad),     32'd0);
        check("b2b_err_no_mem",  32'(we_seen), 32'd0);

        // Back-to-back legal loads: one accept every three cycles.
        wait_idle();
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h0000_0010;
        acc = 0; rsp = 0; bad = 0;
        for (int i = 0; i < 9; i++) begin
            if (req_ready) acc++;
            if (resp_valid) begin
                rsp++;
                if (resp_err || resp_rdata != 32'hEF22_3344) bad++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        $display("[TB] b2b lw: accepts=%0d responses=%0d", acc, rsp);
        check("b2b_lw_accepts", 32'(acc), 32'd3);
        check("b2b_lw_resps",   32'(rsp), 32'd3);
        check("b2b_lw_data",    32'(bad), 32'd0);

        // Reset asserted during ACC0 of a split SW at 0x42.
        wait_idle();
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'h0000_0042;
        req_wdata  = 32'h1234_5678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("abort_acc0_we",   {31'h0, mem_we},  32'h1);
        check("abort_acc0_be",   {28'h0, mem_be},  32'h0000_000C);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_we_drop",   {31'h0, mem_we},    32'h0);
        check("abort_be_drop",   {28'h0, mem_be},    32'h0);
        check("abort_ready",     {31'h0, req_ready}, 32'h1);
        check("abort_mem_addr",  mem_addr,           32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        we_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_we || resp_valid) we_seen++;
        end
        $display("[TB] abort: word16=%h word17=%h", tb_mem[16], tb_mem[17]);
        check("abort_quiet",     32'(we_seen), 32'd0);
        check("abort_word0",     tb_mem[16],   32'h0102_0304);
        check("abort_word1",     tb_mem[17],   32'h5566_7788);
        run_req(1'b0, 3'd2, 32'h0000_0044, 32'h0);
        check("post_abort_lw",   got_rdata,    32'h5566_7788);
        check("post_abort_lat",  32'(got_lat), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule
